// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches to instruction memory and
// buffers up to DEPTH returned {pc, inst} pairs for the IF stage, with redirect on flush.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        deq_en,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [31:0]        r_fetch_pc;
  logic               r_mem_req;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_pc_mem   [DEPTH];
  logic [31:0]        r_inst_mem [DEPTH];

  logic               w_complete;
  logic               w_enq;
  logic               w_deq;
  logic [CNT_W-1:0]   w_count_next;
  logic               w_has_room;
  logic [31:0]        w_flush_pc;
  logic [31:0]        w_fetch_pc_next;
  logic               w_mem_req_next;
  logic [31:0]        w_mem_addr_next;

  assign w_complete   = r_mem_req & mem_ack;
  assign w_deq        = deq_en & (r_count != '0) & ~flush;
  assign w_enq        = (r_state == WAIT) & w_complete & ~flush;
  assign w_count_next = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
  assign w_has_room   = (w_count_next < DEPTH_C);
  assign w_flush_pc   = flush_pc & 32'hFFFF_FFFC;

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_mem_req_next  = r_mem_req;
    w_mem_addr_next = r_mem_addr;
    case (r_state)
      IDLE: begin
        if (flush) begin
          w_fetch_pc_next = w_flush_pc;
        end else if (w_has_room) begin
          w_mem_req_next  = 1'b1;
          w_mem_addr_next = r_fetch_pc & 32'hFFFF_FFFC;
          w_state_next    = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          w_fetch_pc_next = w_flush_pc;
          if (w_complete) begin
            w_mem_req_next = 1'b0;
            w_state_next   = IDLE;
          end else begin
            // Request stays on the bus; its response is discarded in DROP.
            w_state_next = DROP;
          end
        end else if (w_complete) begin
          w_fetch_pc_next = r_mem_addr + 32'd4;
          if (w_has_room) begin
            w_mem_addr_next = r_mem_addr + 32'd4;
          end else begin
            w_mem_req_next = 1'b0;
            w_state_next   = IDLE;
          end
        end
      end
      DROP: begin
        if (flush) begin
          w_fetch_pc_next = w_flush_pc;
        end
        if (w_complete) begin
          w_mem_req_next = 1'b0;
          w_state_next   = IDLE;
        end
      end
      default: begin
        w_mem_req_next = 1'b0;
        w_state_next   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fetch_pc <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_mem_req  <= w_mem_req_next;
      r_mem_addr <= w_mem_addr_next;
      if (flush) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        r_count <= w_count_next;
        if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
    end
  end

  // Storage has no reset; validity is tracked entirely by r_count.
  always_ff @(posedge clk) begin
    if (!rst && w_enq) begin
      r_pc_mem[r_wr_ptr]   <= r_mem_addr;
      r_inst_mem[r_wr_ptr] <= mem_rdata;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? r_pc_mem[r_rd_ptr]   : 32'd0;
  assign out_inst  = out_valid ? r_inst_mem[r_rd_ptr] : 32'd0;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed scenarios plus randomized traffic,
// with a transaction-level model predicting the instruction stream seen by the IF stage.
module tb_inst_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, flush, deq_en, mem_ack;
  logic [31:0] flush_pc, mem_rdata;
  logic        out_valid, mem_req;
  logic [31:0] out_pc, out_inst, mem_addr;

  logic        flush2, deq_en2, mem_ack2;
  logic [31:0] flush_pc2, mem_rdata2;
  logic        out_valid2, mem_req2;
  logic [31:0] out_pc2, out_inst2, mem_addr2;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc), .deq_en(deq_en),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk(clk), .rst(rst), .flush(flush2), .flush_pc(flush_pc2), .deq_en(deq_en2),
    .out_valid(out_valid2), .out_pc(out_pc2), .out_inst(out_inst2),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2), .mem_rdata(mem_rdata2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[15:8], a[23:16], a[31:24]} ^ 32'h5A3C_96E1;
  endfunction

  // ---------------- reference model + monitor ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        sb_q[$];
  logic [31:0] m_fetch = '0;
  logic [31:0] m_held  = '0;
  bit          m_ok = 0, m_out = 0, m_stale = 0, m_exp_req = 0;

  always @(negedge clk) begin : monitor
    int   sz;
    bit   deq, comp, live, stale_b;
    ent_t e;
    sz = sb_q.size();
    if (m_ok) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, sz != 0});
      if (sz != 0) begin
        check("out_pc", out_pc, sb_q[0].pc);
        check("out_inst", out_inst, sb_q[0].inst);
      end else begin
        check("empty_pc", out_pc, 32'd0);
        check("empty_inst", out_inst, 32'd0);
      end
      check("mem_req", {31'd0, mem_req}, {31'd0, m_exp_req});
      if (mem_req && !m_out) begin
        check("issue_addr", mem_addr, m_fetch & 32'hFFFF_FFFC);
        m_out   = 1;
        m_stale = 0;
        m_held  = mem_addr;
      end else if (mem_req) begin
        check("req_hold", mem_addr, m_held);
      end
    end
    // Advance the model across the coming rising edge.
    if (rst) begin
      sb_q.delete();
      m_fetch   = RESET_PC;
      m_out     = 0;
      m_stale   = 0;
      m_exp_req = 0;
      m_ok      = 1;
    end else if (m_ok) begin
      deq     = deq_en && (sz != 0) && !flush;
      comp    = mem_req && mem_ack;
      stale_b = m_stale;
      live    = comp && !stale_b && !flush;
      if (flush) begin
        sb_q.delete();
        m_fetch = flush_pc & 32'hFFFF_FFFC;
        if (mem_req && !comp) m_stale = 1;
      end else begin
        if (deq) begin
          $display("deq pc=%h inst=%h", out_pc, out_inst);
          void'(sb_q.pop_front());
        end
        if (live) begin
          e.pc   = m_fetch;
          e.inst = mem_word(m_fetch);
          sb_q.push_back(e);
          m_fetch = m_fetch + 32'd4;
        end
      end
      if (comp) begin
        m_out   = 0;
        m_stale = 0;
      end
      if (flush)         m_exp_req = mem_req && !comp;
      else if (!mem_req) m_exp_req = (sb_q.size() < DEPTH);
      else if (!comp)    m_exp_req = 1;
      else               m_exp_req = !stale_b && (sb_q.size() < DEPTH);
    end
  end

  // ---------------- stimulus ----------------
  int mode = 1;   // 0 manual ack, 1 zero-wait, 2 random ack, 3 three-cycle latency
  int lat  = 0;

  task automatic step();
    @(posedge clk);
    #1;
    case (mode)
      1: mem_ack = 1'b1;
      2: mem_ack = ($urandom_range(0, 99) < 55);
      3: begin
        if (mem_req) begin
          mem_ack = (lat == 2);
          lat     = (lat == 2) ? 0 : lat + 1;
        end else begin
          mem_ack = 1'b0;
          lat     = 0;
        end
      end
      default: ;
    endcase
    mem_rdata  = mem_word(mem_addr);
    mem_rdata2 = mem_word(mem_addr2);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    flush  = 1'b0;
    deq_en = 1'b0;
    step();
    step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_inst", out_inst, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1; flush = 1'b0; deq_en = 1'b0; mem_ack = 1'b0;
    flush_pc = '0; mem_rdata = '0;
    flush2 = 1'b0; deq_en2 = 1'b1; mem_ack2 = 1'b1; flush_pc2 = '0; mem_rdata2 = '0;

    // Zero-wait, continuous dequeue: one instruction per cycle; wrap-around instance.
    mode = 1;
    do_reset();
    deq_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) check("stream_valid_c2", {31'd0, out_valid}, 32'd0);
      if (k >= 2) begin
        check("stream_valid", {31'd0, out_valid}, 32'd1);
        check("stream_pc", out_pc, 32'(4 * (k - 2)));
        check("stream_inst", out_inst, mem_word(32'(4 * (k - 2))));
      end
      if (k == 1) check("wrap_addr0", mem_addr2, 32'hFFFF_FFF8);
      if (k == 2) check("wrap_addr1", mem_addr2, 32'hFFFF_FFFC);
      if (k == 3) check("wrap_addr2", mem_addr2, 32'h0000_0000);
      if (k == 2) check("wrap_pc0", out_pc2, 32'hFFFF_FFF8);
      if (k == 3) check("wrap_pc1", out_pc2, 32'hFFFF_FFFC);
      if (k == 4) check("wrap_pc2", out_pc2, 32'h0000_0000);
    end

    // No dequeue: queue fills with PC 0..12, then fetching stops until one dequeue.
    do_reset();
    for (int k = 0; k < 10; k++) step();
    check("full_pc", out_pc, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("full_noreq", {31'd0, mem_req}, 32'd0);
      step();
    end
    deq_en = 1'b1;
    step();
    deq_en = 1'b0;
    check("refill_req", {31'd0, mem_req}, 32'd1);
    check("refill_addr", mem_addr, 32'd16);
    check("refill_head", out_pc, 32'd4);
    step();
    check("refill_stop", {31'd0, mem_req}, 32'd0);

    // Flush to 0x40 while the request to 0x8 is pending; its ack arrives later.
    mode = 0;
    mem_ack = 1'b1;
    do_reset();
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (mem_req && mem_addr == 32'd8) found = 1;
    end
    check("find_req8", {31'd0, found}, 32'd1);
    mem_ack  = 1'b0;
    flush    = 1'b1;
    flush_pc = 32'h40;
    step();
    flush = 1'b0;
    check("drop_empty", {31'd0, out_valid}, 32'd0);
    check("drop_hold", mem_addr, 32'd8);
    step();
    mem_ack = 1'b1;
    step();
    check("drop_idle", {31'd0, mem_req}, 32'd0);
    check("drop_nodata", {31'd0, out_valid}, 32'd0);
    step();
    check("redir_addr", mem_addr, 32'h40);
    step();
    check("redir_pc", out_pc, 32'h40);

    // Flush together with dequeue and completion.
    mode = 1;
    do_reset();
    deq_en = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("pre_flush_valid", {31'd0, out_valid}, 32'd1);
    flush    = 1'b1;
    flush_pc = 32'h101;
    step();
    flush = 1'b0;
    check("fl_empty", {31'd0, out_valid}, 32'd0);
    check("fl_idle", {31'd0, mem_req}, 32'd0);
    step();
    check("fl_addr", mem_addr, 32'h100);
    step();
    check("fl_pc", out_pc, 32'h100);

    // Three-cycle memory latency with random dequeue.
    mode = 3;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      deq_en = ($urandom_range(0, 1) == 1);
      step();
    end

    // Randomized traffic across memory modes and dequeue rates.
    for (int seg = 0; seg < 8; seg++) begin
      int deq_pct;
      mode    = 1 + (seg % 3);
      deq_pct = (seg % 2 == 0) ? 80 : 20;
      for (int k = 0; k < 400; k++) begin
        deq_en   = ($urandom_range(0, 99) < deq_pct);
        flush    = ($urandom_range(0, 99) < 4);
        flush_pc = $urandom;
        rst      = ($urandom_range(0, 499) == 0);
        step();
      end
    end
    rst   = 1'b0;
    flush = 1'b0;
    for (int k = 0; k < 5; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have port clk  input  1  main pipeline clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port flush  input  1  redirect request from the ID stage (taken branch/jump).
REQ-006 The block SHALL have port flush_pc  input  32  redirect target address.
REQ-007 The block SHALL have port deq_en  input  1  IF stage consumes the head entry (pipeline PC enable).
REQ-008 The block SHALL have port out_valid  output  1  head entry holds a valid instruction.
REQ-009 The block SHALL have port out_pc  output  32  address of the head instruction.
REQ-010 The block SHALL have port out_inst  output  32  head instruction word.
REQ-011 The block SHALL have port mem_req  output  1  instruction-memory request, registered.
REQ-012 The block SHALL have port mem_addr  output  32  request word address, registered, bits[1:0]=0.
REQ-013 The block SHALL have port mem_ack  input  1  memory response strobe; mem_rdata valid this cycle.
REQ-014 The block SHALL have port mem_rdata  input  32  returned instruction word.

Function
REQ-015 The block SHALL implement states IDLE (no request outstanding), WAIT (live request outstanding) and DROP (stale request outstanding after flush).
REQ-016 A transaction SHALL complete on any rising edge where mem_req=1 and mem_ack=1; mem_ack while mem_req=0 SHALL be ignored.
REQ-017 mem_req and mem_addr SHALL stay constant from issue until completion; at most one request SHALL be outstanding.
REQ-018 In IDLE with no flush and count_next<DEPTH, the block SHALL issue mem_req=1, mem_addr=fetch_pc at the next edge and enter WAIT.
REQ-019 count_next SHALL be count + (enqueue this cycle) - (dequeue this cycle).
REQ-020 On completion in WAIT, the block SHALL write {mem_addr, mem_rdata} at the tail and set fetch_pc=mem_addr+4, with 32-bit wrap (0xFFFF_FFFC+4=0).
REQ-021 On completion in WAIT without flush, if count_next<DEPTH the block SHALL issue the next request (mem_addr+4) at the same edge, staying in WAIT, giving one instruction per cycle with a zero-wait memory; otherwise it SHALL drop mem_req and enter IDLE.
REQ-022 Dequeue SHALL occur when deq_en=1 and out_valid=1; deq_en with the queue empty SHALL have no effect.
REQ-023 Simultaneous enqueue and dequeue SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-024 out_valid SHALL be (count!=0); out_pc/out_inst SHALL be the head entry, and 0 when empty.
REQ-025 A written entry SHALL appear on the outputs one cycle after the completing edge when the queue was empty.
REQ-026 Flush SHALL take priority over enqueue, dequeue and issue: it SHALL empty the queue (count=0, pointers=0) and set fetch_pc=flush_pc&~3.
REQ-027 Flush in WAIT without a same-cycle completion SHALL enter DROP; its eventual response SHALL be discarded, and the block SHALL then drop mem_req and enter IDLE.
REQ-028 Flush coinciding with completion, or flush in IDLE, SHALL discard any returned data and enter IDLE.
REQ-029 Flush in DROP SHALL update fetch_pc only.
REQ-030 The block SHALL never issue a request when count=DEPTH; an overflow or underflow condition SHALL be unreachable.

Reset
REQ-031 When rst=1 at an edge, the block SHALL enter IDLE with count=0, pointers=0, fetch_pc=RESET_PC, mem_req=0, mem_addr=0, out_valid=0, out_pc=0 and out_inst=0.
REQ-032 Reset SHALL override flush and any outstanding request; a mem_ack arriving after reset for a pre-reset request is excluded by the memory protocol.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction, and no entry SHALL be written.

Verification
REQ-034 Reset release, zero-wait memory (ack whenever req), deq_en=1: out_pc SHALL read 0,4,8,12... on consecutive cycles, with out_valid continuously 1 from the 3rd cycle.
REQ-035 deq_en=0, zero-wait memory: exactly 4 entries (PC 0..12) SHALL be queued, mem_req SHALL drop, and no 5th request SHALL issue until a single deq_en pulse.
REQ-036 Memory acks 3 cycles after each request: each request SHALL be held stable for the 3 cycles, and one entry SHALL be written per completion.
REQ-037 Flush with flush_pc=0x40 while a request to 0x8 is pending, ack arriving 2 cycles later: the 0x8 data SHALL be discarded, and the next request SHALL be 0x40, with out_pc=0x40 as the first valid entry.
REQ-038 Flush in the same cycle as deq_en and ack: the queue SHALL be empty next cycle, and no entry from that ack SHALL appear.
REQ-039 RESET_PC=0xFFFF_FFF8: fetch addresses SHALL run 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
